// File: rtl/frame_block_writer.sv
// -----------------------------------------------------------------------------
// frame_block_writer
//   Accepts one 4x4 pixel block per handshake and scatters its 16 bytes into a
//   raster-ordered byte frame memory, one write per cycle, row-major order.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   blk_valid / blk_ready   block handshake (ready only while idle)
//   blk_addr [12:0]         block index, raster order over 4x4 blocks
//   blk_row0..3 [31:0]      block pixel rows, [31:24] = leftmost column
//   mem_we                  frame memory byte write strobe
//   mem_addr [16:0]         byte address (row*FRAME_W + col)
//   mem_data [7:0]          byte to write
//   busy                    high while a block is in WRITE or DONE
//   done                    one-cycle pulse after the 16th write
//   err                     one-cycle pulse for an out-of-range block index
// -----------------------------------------------------------------------------
module frame_block_writer #(
  parameter int unsigned FRAME_W     = 320,
  parameter int unsigned FRAME_H     = 240,
  parameter int unsigned BLK_PER_ROW = FRAME_W / 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [12:0] blk_addr,
  input  logic [31:0] blk_row0,
  input  logic [31:0] blk_row1,
  input  logic [31:0] blk_row2,
  input  logic [31:0] blk_row3,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW      = 17;
  localparam int unsigned NUM_BLK = (FRAME_W / 4) * (FRAME_H / 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [3:0][31:0]  rows_q, rows_d;
  logic [AW-1:0]     base_q, base_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic              in_range_c;
  logic [31:0]       blk_y_c;
  logic [31:0]       blk_x_c;
  logic [31:0]       new_base_c;
  logic [3:0]        nk_c;
  logic [31:0]       wr_addr_c;

  // Byte c of a row; column 0 lives in the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] row, input logic [1:0] c);
    logic [7:0] b;
    case (c)
      2'd0:    b = row[31:24];
      2'd1:    b = row[23:16];
      2'd2:    b = row[15:8];
      default: b = row[7:0];
    endcase
    return b;
  endfunction

  // Block index -> byte address of its top-left pixel.
  always_comb begin
    in_range_c = 32'(blk_addr) < NUM_BLK;
    blk_y_c    = 32'(blk_addr) / BLK_PER_ROW;
    blk_x_c    = 32'(blk_addr) % BLK_PER_ROW;
    new_base_c = (blk_y_c * 4 * FRAME_W) + (blk_x_c * 4);
  end

  // Address of the write that follows the current one (k+1).
  always_comb begin
    nk_c      = k_q + 4'd1;
    wr_addr_c = 32'(base_q) + (32'(nk_c[3:2]) * FRAME_W) + 32'(nk_c[1:0]);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rows_d     = rows_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          rows_d = {blk_row3, blk_row2, blk_row1, blk_row0};
          if (in_range_c) begin
            // First write is presented straight from the handshake inputs so
            // it appears in the cycle right after acceptance.
            base_d     = AW'(new_base_c);
            k_d        = 4'd0;
            mem_addr_d = AW'(new_base_c);
            mem_data_d = blk_row0[31:24];
            state_d    = S_WRITE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        if (k_q == 4'hf) begin
          k_d     = 4'd0;
          state_d = S_DONE;
        end else begin
          k_d        = nk_c;
          mem_addr_d = AW'(wr_addr_c);
          mem_data_d = byte_sel(rows_q[nk_c[3:2]], nk_c[1:0]);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_we_d = (state_d == S_WRITE);
    busy_d   = (state_d == S_WRITE) || (state_d == S_DONE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
    ready_d  = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 4'd0;
      rows_q     <= '0;
      base_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      rows_q     <= rows_d;
      base_q     <= base_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign blk_ready = ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_frame_block_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_block_writer
//   Directed bench for frame_block_writer: reset state, full block writes at
//   several frame positions, out-of-range index, reset mid-block, and inputs
//   wiggling during a write with blk_valid held high.
// -----------------------------------------------------------------------------
module tb_frame_block_writer;

  logic        clk;
  logic        rst_n;
  logic        blk_valid;
  logic        blk_ready;
  logic [12:0] blk_addr;
  logic [31:0] blk_row0, blk_row1, blk_row2, blk_row3;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rows [4];

  frame_block_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_addr  (blk_addr),
    .blk_row0  (blk_row0),
    .blk_row1  (blk_row1),
    .blk_row2  (blk_row2),
    .blk_row3  (blk_row3),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rows();
    blk_row0 = rows[0];
    blk_row1 = rows[1];
    blk_row2 = rows[2];
    blk_row3 = rows[3];
  endtask

  // Present a block and complete the handshake; returns in cycle N+1.
  task automatic handshake(input logic [12:0] a, input bit hold);
    int n;
    n = 0;
    blk_addr  = a;
    drive_rows();
    blk_valid = 1'b1;
    while (blk_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", 32'(blk_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) blk_valid = 1'b0;
  endtask

  // Check write number i of the block whose top-left pixel is at base.
  task automatic check_write(input int i, input int base);
    int r, c;
    logic [7:0] d;
    r = i / 4;
    c = i % 4;
    d = 8'(rows[r] >> (24 - 8 * c));
    chk($sformatf("wr%0d_we", i), 32'(mem_we), 32'd1);
    chk($sformatf("wr%0d_addr", i), 32'(mem_addr), 32'(base + r * 320 + c));
    chk($sformatf("wr%0d_data", i), 32'(mem_data), 32'(d));
  endtask

  // Called in cycle N+1; returns in cycle N+17 after checking the done cycle.
  task automatic check_block(input int base, input bit scramble);
    for (int i = 0; i < 16; i++) begin
      check_write(i, base);
      if (i == 0) begin
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_ready", 32'(blk_ready), 32'd0);
      end
      if (i == 15) chk("wr_done_early", 32'(done), 32'd0);
      if (scramble) begin
        blk_row0 = $urandom;
        blk_row1 = $urandom;
        blk_row2 = $urandom;
        blk_row3 = $urandom;
        blk_addr = 13'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_we", 32'(mem_we), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(blk_ready), 32'd0);
    chk("done_addr_hold", 32'(mem_addr), 32'(base + 963));
  endtask

  task automatic finish_idle();
    @(posedge clk); #1;
    chk("idle_ready", 32'(blk_ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_addr  = '0;
    blk_row0  = '0;
    blk_row1  = '0;
    blk_row2  = '0;
    blk_row3  = '0;

    // Reset state.
    #12;
    chk("rst_ready", 32'(blk_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Block 0 at the frame origin.
    rows[0] = 32'h00010203;
    rows[1] = 32'h10111213;
    rows[2] = 32'h20212223;
    rows[3] = 32'h30313233;
    handshake(13'd0, 1'b0);
    check_block(0, 1'b0);
    finish_idle();

    // Block 81: second block row, second column -> base 1284, last 2247.
    rows[0] = 32'hA0A1A2A3;
    rows[1] = 32'hB4B5B6B7;
    rows[2] = 32'hC8C9CACB;
    rows[3] = 32'hDCDDDEDF;
    handshake(13'd81, 1'b0);
    check_block(1284, 1'b0);
    finish_idle();

    // Last block 4799 -> base 75836, last 76799.
    rows[0] = 32'hDEADBEEF;
    rows[1] = 32'h01234567;
    rows[2] = 32'h89ABCDEF;
    rows[3] = 32'hFEDCBA98;
    handshake(13'd4799, 1'b0);
    check_block(75836, 1'b0);
    finish_idle();

    // First out-of-range index: err pulse only, address holds.
    handshake(13'd4800, 1'b0);
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_we", 32'(mem_we), 32'd0);
    chk("err_done", 32'(done), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_ready", 32'(blk_ready), 32'd0);
    chk("err_addr_hold", 32'(mem_addr), 32'd76799);
    @(posedge clk); #1;
    chk("err_after_ready", 32'(blk_ready), 32'd1);
    chk("err_after_err", 32'(err), 32'd0);

    // Largest index also rejected.
    handshake(13'd8191, 1'b0);
    chk("err8191_pulse", 32'(err), 32'd1);
    chk("err8191_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("err8191_ready", 32'(blk_ready), 32'd1);

    // Reset after the 5th write of block 2 (base 8).
    rows[0] = 32'h11223344;
    rows[1] = 32'h55667788;
    rows[2] = 32'h99AABBCC;
    rows[3] = 32'hDDEEFF00;
    handshake(13'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_write(i, 8);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_data", 32'(mem_data), 32'd0);
    chk("midrst_ready", 32'(blk_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 32'(blk_ready), 32'd1);
    chk("postrst_we", 32'(mem_we), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("postrst_no_done", 32'(saw_done), 32'd0);

    // Next block after reset: 4000 -> block row 50, col 0 -> base 64000.
    rows[0] = 32'h0F1E2D3C;
    rows[1] = 32'h4B5A6978;
    rows[2] = 32'h8796A5B4;
    rows[3] = 32'hC3D2E1F0;
    handshake(13'd4000, 1'b0);
    check_block(64000, 1'b0);
    finish_idle();

    // Valid held high, inputs scrambled during the write: block 160 -> base 2560.
    rows[0] = 32'h12345678;
    rows[1] = 32'h9ABCDEF0;
    rows[2] = 32'h0FEDCBA9;
    rows[3] = 32'h87654321;
    handshake(13'd160, 1'b1);
    check_block(2560, 1'b1);
    // Now in done cycle N+17: present the second block (index 5 -> base 20).
    rows[0] = 32'hC0C1C2C3;
    rows[1] = 32'hD0D1D2D3;
    rows[2] = 32'hE0E1E2E3;
    rows[3] = 32'hF0F1F2F3;
    blk_addr = 13'd5;
    drive_rows();
    @(posedge clk); #1;
    chk("hold_n18_ready", 32'(blk_ready), 32'd1);
    chk("hold_n18_we", 32'(mem_we), 32'd0);
    chk("hold_n18_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    check_block(20, 1'b0);
    finish_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_block_writer.md
FRAME_BLOCK_WRITER -- requirements
Module: frame_block_writer

Interface
REQ-001 Parameter FRAME_W, default 320: frame width in pixels (bytes).
REQ-002 Parameter FRAME_H, default 240: frame height in pixels.
REQ-003 Parameter BLK_PER_ROW, default FRAME_W/4 (80): 4x4 blocks per block row.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 blk_valid  input  1  block presented on blk_addr and blk_row0..3.
REQ-007 blk_ready  output  1  writer can accept a block this cycle.
REQ-008 blk_addr  input  13  block index, raster order over 4x4 blocks (0..4799 valid).
REQ-009 blk_row0..blk_row3  input  32 each  block pixel rows; [31:24]=col 0, [23:16]=col 1, [15:8]=col 2, [7:0]=col 3.
REQ-010 mem_we  output  1  frame memory byte write strobe.
REQ-011 mem_addr  output  17  frame memory byte address (row*FRAME_W + col).
REQ-012 mem_data  output  8  byte to write.
REQ-013 busy  output  1  high while a block is being written.
REQ-014 done  output  1  one-cycle pulse: block fully written.
REQ-015 err  output  1  one-cycle pulse: accepted block address out of range.

Function
REQ-016 FSM states IDLE, WRITE, DONE, ERR; blk_ready SHALL equal (state==IDLE).
REQ-017 Handshake: transfer occurs on a rising edge with blk_valid && blk_ready; blk_addr and all four rows SHALL be captured into registers at that edge.
REQ-018 Inputs SHALL be ignored outside the handshake edge; changes during WRITE do not affect written data.
REQ-019 On accept with blk_addr < (FRAME_W/4)*(FRAME_H/4): base = (blk_addr / BLK_PER_ROW)*4*FRAME_W + (blk_addr % BLK_PER_ROW)*4, registered; go to WRITE.
REQ-020 On accept with blk_addr >= 4800: go to ERR, no mem_we; ERR lasts one cycle with err=1, then IDLE.
REQ-021 WRITE: 4-bit counter k=0..15, r=k[3:2], c=k[1:0]; each cycle mem_we=1, mem_addr=base + r*FRAME_W + c, mem_data=byte c of captured row r.
REQ-022 Write order row-major: r0c0..r0c3, r1c0..r1c3, r2c0.., r3c0..r3c3; exactly 16 writes, one per cycle, no gaps.
REQ-023 Latency: handshake at edge N -> first write visible cycle N+1, last write cycle N+16, done=1 cycle N+17 (DONE state), blk_ready=1 cycle N+18.
REQ-024 busy SHALL be 1 in WRITE and DONE, 0 in IDLE and ERR.
REQ-025 mem_we SHALL be 0 in IDLE, DONE and ERR; mem_addr/mem_data hold last value when mem_we=0.
REQ-026 Address arithmetic in at least 17 bits; maximum generated address 76799 (FRAME_W*FRAME_H-1), never exceeded.
REQ-027 done and err SHALL never be asserted in the same cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0, captured registers 0.
REQ-029 Reset mid-WRITE abandons remaining writes; no done pulse for that block; blk_ready=1 first cycle after rst_n rises.

Verification
REQ-030 blk_addr=0, rows 0x00010203/0x10111213/0x20212223/0x30313233 -> writes addr 0,1,2,3,320..323,640..643,960..963 with data 00,01,02,03,10..13,20..23,30..33; done at N+17.
REQ-031 blk_addr=81 -> base 1284; first mem_addr 1284, last 2247; 16 writes.
REQ-032 blk_addr=4799 -> base 75836; last mem_addr 76799; done pulse, no err.
REQ-033 blk_addr=4800 -> no mem_we, err=1 one cycle at N+1, blk_ready=1 at N+2.
REQ-034 rst_n low after 5th write of a block -> mem_we 0 asynchronously, no done, blk_ready=1 after release; next block writes correctly.
REQ-035 blk_valid held high, rows altered every cycle during WRITE -> written data matches values captured at handshake; second block accepted only at N+18.
